// File: rtl/cpu_step_sequencer.sv
// Command sequencer for the 4-bit nibble CPU: turns host commands into core mode/data/step
// sequences and returns one response per command. Define SEQ_TRACE_EN for per-step trace outputs.
module cpu_step_sequencer #(
    parameter int unsigned STEP_GAP  = 0,
    parameter logic [7:0]  MAX_STEPS = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_arg,
    input  logic       cmd_cond,
    input  logic       abort,
    output logic       core_step,
    output logic [1:0] core_instruction,
    output logic [3:0] core_data_in,
    output logic       core_cond,
    input  logic [3:0] core_pc,
    input  logic [3:0] core_regval,
    output logic       rsp_valid,
    output logic [3:0] rsp_pc,
    output logic [3:0] rsp_regval,
    output logic [1:0] rsp_status,
    output logic       busy
`ifdef SEQ_TRACE_EN
    ,
    output logic       trace_valid,
    output logic [3:0] trace_pc,
    output logic [3:0] trace_regval,
    output logic [7:0] trace_idx
`endif
);

    typedef enum logic [2:0] {IDLE, STEP, CHECK, GAP, DONE} state_t;

    localparam logic [2:0] OP_LOADP     = 3'd0;
    localparam logic [2:0] OP_LOADD     = 3'd1;
    localparam logic [2:0] OP_SETPC     = 3'd2;
    localparam logic [2:0] OP_RUN_N     = 3'd3;
    localparam logic [2:0] OP_RUN_UNTIL = 3'd4;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ABORT   = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    localparam logic [15:0] GAP_LAST = (STEP_GAP > 0) ? 16'(STEP_GAP - 1) : 16'd0;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [3:0]  arg_q;
    logic [7:0]  step_cnt;
    logic [15:0] gap_cnt;
    logic [1:0]  status_nxt;
    logic [3:0]  pc_hold, reg_hold;
    logic [7:0]  run_n_total;
    logic        accept, is_run, abort_run;
    state_t      after_check;

    assign accept      = cmd_valid & (state == IDLE);
    assign is_run      = (op_q == OP_RUN_N) | (op_q == OP_RUN_UNTIL);
    // abort only matters while a run op is active; single ops and IDLE/DONE ignore it
    assign abort_run   = is_run & abort;
    assign run_n_total = {4'b0, arg_q} + 8'd1;
    assign after_check = (STEP_GAP == 0) ? STEP : GAP;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign core_step = (state == STEP) & ~abort_run;
    assign rsp_valid = (state == DONE);
    // during DONE the response shows the live (post-step) core values, then holds them
    assign rsp_pc     = (state == DONE) ? core_pc     : pc_hold;
    assign rsp_regval = (state == DONE) ? core_regval : reg_hold;

    always_comb begin
        state_nxt  = state;
        status_nxt = ST_OK;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_op > OP_RUN_UNTIL) begin
                        state_nxt  = DONE;
                        status_nxt = ST_ILLEGAL;
                    end else begin
                        state_nxt = STEP;
                    end
                end
            end
            STEP: begin
                if (abort_run) begin
                    state_nxt  = DONE;
                    status_nxt = ST_ABORT;
                end else if (is_run) begin
                    state_nxt = CHECK;
                end else begin
                    state_nxt = DONE;
                end
            end
            CHECK: begin
                if (abort_run) begin
                    state_nxt  = DONE;
                    status_nxt = ST_ABORT;
                end else if (op_q == OP_RUN_N) begin
                    state_nxt = (step_cnt == run_n_total) ? DONE : after_check;
                end else if (core_pc == arg_q) begin
                    state_nxt = DONE;
                end else if (step_cnt == MAX_STEPS) begin
                    state_nxt  = DONE;
                    status_nxt = ST_TIMEOUT;
                end else begin
                    state_nxt = after_check;
                end
            end
            GAP: begin
                if (abort_run) begin
                    state_nxt  = DONE;
                    status_nxt = ST_ABORT;
                end else if (gap_cnt == GAP_LAST) begin
                    state_nxt = STEP;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            op_q             <= 3'd0;
            arg_q            <= 4'd0;
            core_instruction <= 2'b00;
            core_data_in     <= 4'd0;
            core_cond        <= 1'b0;
            step_cnt         <= 8'd0;
            gap_cnt          <= 16'd0;
            rsp_status       <= ST_OK;
            pc_hold          <= 4'd0;
            reg_hold         <= 4'd0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                op_q      <= cmd_op;
                arg_q     <= cmd_arg;
                core_cond <= cmd_cond;
                step_cnt  <= 8'd0;
                // illegal ops leave the core mode/data untouched since no step is issued
                case (cmd_op)
                    OP_LOADP:     begin core_instruction <= 2'b00; core_data_in <= cmd_arg; end
                    OP_LOADD:     begin core_instruction <= 2'b01; core_data_in <= cmd_arg; end
                    OP_SETPC:     begin core_instruction <= 2'b10; core_data_in <= cmd_arg; end
                    OP_RUN_N,
                    OP_RUN_UNTIL: begin core_instruction <= 2'b11; core_data_in <= cmd_arg; end
                    default: ;
                endcase
            end else if (core_step && is_run) begin
                step_cnt <= step_cnt + 8'd1;
            end

            if (state == GAP) gap_cnt <= gap_cnt + 16'd1;
            else              gap_cnt <= 16'd0;

            if (state_nxt == DONE) rsp_status <= status_nxt;

            if (state == DONE) begin
                pc_hold  <= core_pc;
                reg_hold <= core_regval;
            end
        end
    end

`ifdef SEQ_TRACE_EN
    assign trace_valid  = (state == CHECK);
    assign trace_pc     = trace_valid ? core_pc     : 4'd0;
    assign trace_regval = trace_valid ? core_regval : 4'd0;
    assign trace_idx    = trace_valid ? step_cnt    : 8'd0;
`endif

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Directed bench for cpu_step_sequencer with a small behavioural nibble-core model
// (load-prog/load-data/set-pc/run) driven by the sequencer outputs.
module tb_cpu_step_sequencer;

    localparam int unsigned GAP  = 2;
    localparam logic [7:0]  MAXS = 8'd4;

    logic       clk, rst_n;
    logic       cmd_valid, cmd_ready, cmd_cond, abort;
    logic [2:0] cmd_op;
    logic [3:0] cmd_arg;
    logic       core_step, core_cond;
    logic [1:0] core_instruction;
    logic [3:0] core_data_in, core_pc, core_regval;
    logic       rsp_valid, busy;
    logic [3:0] rsp_pc, rsp_regval;
    logic [1:0] rsp_status;
`ifdef SEQ_TRACE_EN
    logic       trace_valid;
    logic [3:0] trace_pc, trace_regval;
    logic [7:0] trace_idx;
`endif

    int checks = 0;
    int failures = 0;

    cpu_step_sequencer #(.STEP_GAP(GAP), .MAX_STEPS(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_arg(cmd_arg), .cmd_cond(cmd_cond), .abort(abort),
        .core_step(core_step), .core_instruction(core_instruction),
        .core_data_in(core_data_in), .core_cond(core_cond),
        .core_pc(core_pc), .core_regval(core_regval),
        .rsp_valid(rsp_valid), .rsp_pc(rsp_pc), .rsp_regval(rsp_regval),
        .rsp_status(rsp_status), .busy(busy)
`ifdef SEQ_TRACE_EN
        , .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_regval(trace_regval), .trace_idx(trace_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural core: LOADP writes prog[pc] and advances, LOADD sets reg,
    // SETPC jumps, RUN adds prog[pc] into reg and advances
    logic [3:0] m_prog [16] = '{default: 4'h0};
    logic [3:0] m_pc  = 4'd0;
    logic [3:0] m_reg = 4'd0;
    assign core_pc     = m_pc;
    assign core_regval = m_reg;

    always @(posedge clk) begin
        if (core_step) begin
            case (core_instruction)
                2'b00: begin m_prog[m_pc] <= core_data_in; m_pc <= m_pc + 4'd1; end
                2'b01: m_reg <= core_data_in;
                2'b10: m_pc <= core_data_in;
                default: begin m_reg <= m_reg + m_prog[m_pc]; m_pc <= m_pc + 4'd1; end
            endcase
        end
    end

    typedef struct {
        logic [2:0] op;
        logic [3:0] arg;
        logic       cond;
        int         abort_at;
        logic [1:0] instr;
        logic [3:0] pc;
        logic [3:0] regv;
        logic [1:0] st;
        int         steps;
        int         lat;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_cmd(input int idx, input vec_t v);
        int  lat, steps, prev_step;
        bit  got, busy_ok, instr_ok, gap_ok;
        logic [3:0] r_pc, r_reg;
        logic [1:0] r_st;
        string p;
        p = $sformatf("row%0d", idx);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_arg = v.arg; cmd_cond = v.cond;
        #1;
        chk({p, "_ready"}, int'(cmd_ready), 1);
        lat = 0; steps = 0; prev_step = 0; got = 0;
        busy_ok = 1; instr_ok = 1; gap_ok = 1;
        r_pc = 0; r_reg = 0; r_st = 0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            cmd_valid = 1'b0;
            abort = (lat == v.abort_at);
            #1;
            if (lat == 1) chk({p, "_core_cond"}, int'(core_cond), int'(v.cond));
            if (!busy) busy_ok = 0;
            if (core_step) begin
                steps++;
                if (core_instruction != v.instr || core_data_in != v.arg) instr_ok = 0;
                if (prev_step != 0 && lat - prev_step != int'(GAP) + 2) gap_ok = 0;
                prev_step = lat;
            end
            if (rsp_valid) begin
                got = 1; r_pc = rsp_pc; r_reg = rsp_regval; r_st = rsp_status;
            end
        end
        abort = 1'b0;
        chk({p, "_rsp_seen"}, int'(got), 1);
        chk({p, "_latency"}, lat, v.lat);
        chk({p, "_steps"}, steps, v.steps);
        chk({p, "_rsp_pc"}, int'(r_pc), int'(v.pc));
        chk({p, "_rsp_regval"}, int'(r_reg), int'(v.regv));
        chk({p, "_rsp_status"}, int'(r_st), int'(v.st));
        chk({p, "_busy"}, int'(busy_ok), 1);
        if (v.steps > 0) chk({p, "_instr_data"}, int'(instr_ok), 1);
        if (v.steps > 1) chk({p, "_step_period"}, int'(gap_ok), 1);
        @(negedge clk);
        #1;
        chk({p, "_strobe_len"}, int'(rsp_valid), 0);
        chk({p, "_ready_after"}, int'(cmd_ready), 1);
        chk({p, "_pc_hold"}, int'(rsp_pc), int'(v.pc));
    endtask

    initial begin
        int n;
        //            op    arg  cond ab  instr  pc  reg  st    steps lat
        tbl[0]  = '{3'd0, 4'd3,  1'b0, 0, 2'b00, 4'd1, 4'd0,  2'b00, 1, 2};
        tbl[1]  = '{3'd0, 4'd2,  1'b1, 0, 2'b00, 4'd2, 4'd0,  2'b00, 1, 2};
        tbl[2]  = '{3'd0, 4'd0,  1'b0, 0, 2'b00, 4'd3, 4'd0,  2'b00, 1, 2};
        tbl[3]  = '{3'd1, 4'd7,  1'b1, 0, 2'b01, 4'd3, 4'd7,  2'b00, 1, 2};
        tbl[4]  = '{3'd2, 4'd5,  1'b0, 0, 2'b10, 4'd5, 4'd7,  2'b00, 1, 2};
        tbl[5]  = '{3'd2, 4'd0,  1'b0, 0, 2'b10, 4'd0, 4'd7,  2'b00, 1, 2};
        tbl[6]  = '{3'd3, 4'd3,  1'b1, 0, 2'b11, 4'd4, 4'd12, 2'b00, 4, 15};
        tbl[7]  = '{3'd2, 4'd6,  1'b0, 0, 2'b10, 4'd6, 4'd12, 2'b00, 1, 2};
        tbl[8]  = '{3'd4, 4'd9,  1'b0, 0, 2'b11, 4'd9, 4'd12, 2'b00, 3, 11};
        tbl[9]  = '{3'd2, 4'd0,  1'b0, 0, 2'b10, 4'd0, 4'd12, 2'b00, 1, 2};
        tbl[10] = '{3'd4, 4'd15, 1'b0, 0, 2'b11, 4'd4, 4'd1,  2'b01, 4, 15};
        tbl[11] = '{3'd6, 4'd0,  1'b1, 0, 2'b11, 4'd4, 4'd1,  2'b11, 0, 1};
        tbl[12] = '{3'd3, 4'd15, 1'b0, 9, 2'b11, 4'd6, 4'd1,  2'b10, 2, 10};
        tbl[13] = '{3'd3, 4'd0,  1'b0, 0, 2'b11, 4'd7, 4'd1,  2'b00, 1, 3};
        tbl[14] = '{3'd4, 4'd8,  1'b0, 0, 2'b11, 4'd8, 4'd1,  2'b00, 1, 3};
        tbl[15] = '{3'd1, 4'd4,  1'b0, 1, 2'b01, 4'd8, 4'd4,  2'b00, 1, 2};
        tbl[16] = '{3'd7, 4'd2,  1'b0, 0, 2'b11, 4'd8, 4'd4,  2'b11, 0, 1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 4'd0;
        cmd_cond = 1'b0; abort = 1'b0;
        #3;
        chk("reset_ready", int'(cmd_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_step", int'(core_step), 0);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_status", int'(rsp_status), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) run_cmd(i, tbl[i]);

        // asynchronous reset in the middle of a long RUN_N
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_arg = 4'd15; cmd_cond = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", int'(cmd_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_step", int'(core_step), 0);
        chk("midrst_instr", int'(core_instruction), 0);
        chk("midrst_data", int'(core_data_in), 0);
        chk("midrst_cond", int'(core_cond), 0);
        chk("midrst_rsp_valid", int'(rsp_valid), 0);
        chk("midrst_rsp_pc", int'(rsp_pc), 0);
        chk("midrst_rsp_regval", int'(rsp_regval), 0);
        chk("midrst_status", int'(rsp_status), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (core_step || rsp_valid || busy) n++;
        end
        chk("postrst_quiet", n, 0);
        chk("postrst_ready", int'(cmd_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_step_sequencer.md
Name: cpu_step_sequencer

Overview:
- Command-driven controller that sequences the 4-bit nibble CPU core.
- Drives the core's mode select, nibble data, jump-condition and step-enable inputs.
- Host (RP2040 bridge) issues one command per valid/ready handshake: load a program nibble, load a data nibble, set PC, run N steps, or run until a target PC.
- Returns a single response (final PC, register value, status) per command.

Parameters:
- STEP_GAP, 0, extra idle clk cycles inserted after each run-step check cycle (pacing for display/debug).
- MAX_STEPS, 255, RUN_UNTIL step budget before timeout; range 1..255, counter is 8 bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  0=LOADP, 1=LOADD, 2=SETPC, 3=RUN_N, 4=RUN_UNTIL, 5..7 illegal
- cmd_arg  in  4  nibble / PC / (step count - 1) / target PC
- cmd_cond  in  1  jump condition to present to core
- abort  in  1  stop an in-progress run
- core_step  out  1  one-cycle step enable to core
- core_instruction  out  2  core mode: 00 load prog, 01 load data, 10 set PC, 11 run
- core_data_in  out  4  nibble to core
- core_cond  out  1  core jump condition
- core_pc  in  4  core program counter
- core_regval  in  4  core result register
- rsp_valid  out  1  one-cycle response strobe
- rsp_pc  out  4  core_pc at completion
- rsp_regval  out  4  core_regval at completion
- rsp_status  out  2  00 OK, 01 TIMEOUT, 10 ABORT, 11 ILLEGAL
- busy  out  1  command in progress

Behaviour:
- States: IDLE, STEP, CHECK, GAP, DONE.
- cmd_ready = 1 only in IDLE. Handshake = cmd_valid & cmd_ready in cycle T.
- Reset values: state IDLE, cmd_ready 1, busy 0, core_step 0, core_instruction 00, core_data_in 0, core_cond 0, rsp_valid 0, rsp_pc 0, rsp_regval 0, rsp_status 00, step counter 0.
- On accept:
  - Latch op, arg and cond.
  - core_cond takes cmd_cond from T+1 and holds until the next accepted command.
  - busy = 1 from T+1 until the DONE cycle inclusive.
- core_instruction/core_data_in:
  - Set at T+1 and held stable for the whole command.
  - Mapping: LOADP→00/arg, LOADD→01/arg, SETPC→10/arg, RUN_N and RUN_UNTIL→11/arg.
- Single ops (LOADP/LOADD/SETPC):
  - STEP at T+1 (core_step = 1).
  - DONE at T+2: rsp_valid = 1, rsp_pc/rsp_regval sampled from core (post-update), status OK.
  - IDLE at T+3.
- Run ops:
  - Sequence per step: STEP (core_step = 1) → CHECK → STEP_GAP cycles of GAP → next STEP.
  - Step period = STEP_GAP + 2 cycles.
  - Step counter increments on each STEP.
  - RUN_N: exactly arg + 1 steps (1..16). After the CHECK of the final step → DONE, status OK.
  - RUN_UNTIL: at least one step always executes.
    - In CHECK, core_pc == arg → DONE, status OK.
    - Else, counter == MAX_STEPS → DONE, status TIMEOUT.
    - Else continue. The match test has priority over timeout.
- abort:
  - Sampled in STEP, CHECK and GAP of run ops.
  - In STEP, abort suppresses core_step for that cycle.
  - Any sampled abort → DONE next cycle, status ABORT. No further steps are issued.
  - Ignored in IDLE, DONE and single ops.
- Illegal op (5..7): no step; DONE at T+1, status ILLEGAL, rsp_pc/rsp_regval = current core values.
- rsp_* fields hold their values after the strobe until the next DONE.
- Reset asserted mid-command: immediate return to reset values; no partial step is issued after deassertion.
- Counter width 8 bits, no wrap: MAX_STEPS ≤ 255 is enforced by parameter range.

Optional Feature:
- Macro: SEQ_TRACE_EN.
- When defined, adds outputs:
  - trace_valid (1): pulses in every run-op CHECK cycle.
  - trace_pc (4), trace_regval (4): core values in that cycle.
  - trace_idx (8): step counter value, first step = 1.
- All trace outputs reset to 0.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- LOADP with args 3,2,0 back-to-back from core_pc 0:
  - each command gives exactly one core_step with instr 00;
  - rsp_pc values are 1, 2, 3; rsp_valid exactly 2 cycles after each accept; status 00.
- SETPC arg 5 → one step with instr 10 / data 5; rsp_pc = 5, status OK.
- RUN_N arg 3, STEP_GAP = 2 → four core_step pulses exactly 4 cycles apart; busy high throughout; rsp after the fourth CHECK.
- RUN_UNTIL arg 9, core_pc stepping 6,7,8,9 → three steps, rsp_pc = 9, status OK.
  - With an unreachable target and MAX_STEPS = 4: exactly 4 steps, status TIMEOUT.
- RUN_N arg 15 with abort pulsed in the third STEP cycle → only 2 core_step pulses observed; status ABORT; cmd_ready returns 1 the cycle after DONE.
- cmd_op 6 → no core_step, status ILLEGAL at T+1.
  - Separately, rst_n pulsed low mid-RUN_N → all outputs return to reset values asynchronously; no step after release.
